// File: rtl/mavg_pkg.sv
// Shared constants, types and helpers for the moving-average filter.
// Imported by the delay line and the filter top level.
package mavg_pkg;

  localparam int MAVG_MAX_LOG2_TAPS = 6;

  // Wide enough to hold N for the largest legal window.
  typedef logic [MAVG_MAX_LOG2_TAPS:0] fill_t;

  function automatic int acc_width(input int width, input int log2_taps);
    return width + log2_taps;
  endfunction

endpackage

// File: rtl/moving_avg_filter_if.sv
// Sample stream and result bundle between the source, the filter and downstream logic.
// The master modport drives samples and flush; the slave modport is the filter.
interface moving_avg_filter_if #(
  parameter int WIDTH = 8
);
  logic                    clear;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_sample;
  logic                    out_valid;
  logic signed [WIDTH-1:0] result;
  logic                    primed;

  modport master (
    output clear, in_valid, in_sample,
    input  out_valid, result, primed
  );

  modport slave (
    input  clear, in_valid, in_sample,
    output out_valid, result, primed
  );
endinterface

// File: rtl/mavg_delay_line.sv
// N x WIDTH circular sample store; the entry at wr_ptr is the oldest sample
// and is presented combinationally so the running sum can retire it on the same edge.
module mavg_delay_line
  import mavg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LOG2_TAPS = 2
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    we,
  input  logic [LOG2_TAPS-1:0]    wr_ptr,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] oldest
);

  localparam int N = 1 << LOG2_TAPS;

  logic signed [WIDTH-1:0] mem [N];

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= din;
    end
  end

  assign oldest = mem[wr_ptr];

endmodule

// File: rtl/moving_avg_filter.sv
// N-tap boxcar filter with running sum, warm-up flag and synchronous flush.
// Define MAVG_ROUND_EN to round half toward +inf instead of flooring the average.
module moving_avg_filter
  import mavg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LOG2_TAPS = 2
) (
  input logic                 CLK100MHZ,
  input logic                 reset,
  moving_avg_filter_if.slave  bus
);

  localparam int N  = 1 << LOG2_TAPS;
  localparam int AW = acc_width(WIDTH, LOG2_TAPS);

  logic [LOG2_TAPS-1:0]    wr_ptr;
  fill_t                   fill;
  fill_t                   fill_next;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    sum_next;
  logic signed [WIDTH-1:0] oldest;
  logic signed [WIDTH-1:0] avg;
  logic                    accept;

  assign accept = bus.in_valid & ~bus.clear;

  mavg_delay_line #(
    .WIDTH     (WIDTH),
    .LOG2_TAPS (LOG2_TAPS)
  ) u_delay_line (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .flush     (bus.clear),
    .we        (accept),
    .wr_ptr    (wr_ptr),
    .din       (bus.in_sample),
    .oldest    (oldest)
  );

  // Zeroed entries retire as 0, so the sum is exact while the window fills.
  assign sum_next = sum
                  + {{LOG2_TAPS{bus.in_sample[WIDTH-1]}}, bus.in_sample}
                  - {{LOG2_TAPS{oldest[WIDTH-1]}}, oldest};

  assign fill_next = (fill == fill_t'(N)) ? fill : fill + 1'b1;

`ifdef MAVG_ROUND_EN
  localparam logic [AW:0] HALF = (AW+1)'(1) << (LOG2_TAPS - 1);
  logic signed [AW:0] rnd;
  assign rnd = {sum_next[AW-1], sum_next} + HALF;
  assign avg = WIDTH'(rnd >>> LOG2_TAPS);
`else
  assign avg = WIDTH'(sum_next >>> LOG2_TAPS);
`endif

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sum           <= '0;
      fill          <= '0;
      wr_ptr        <= '0;
      bus.result    <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.clear) begin
      sum           <= '0;
      fill          <= '0;
      wr_ptr        <= '0;
      bus.result    <= '0;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      sum           <= sum_next;
      fill          <= fill_next;
      wr_ptr        <= wr_ptr + 1'b1;
      bus.result    <= avg;
      bus.out_valid <= (fill_next == fill_t'(N));
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

  assign bus.primed = (fill == fill_t'(N));

endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter: directed scenarios plus random traffic
// against a queue-based window-average model; second instance uses an 8-tap window.
module tb_moving_avg_filter;

  logic CLK100MHZ = 1'b0;
  logic reset     = 1'b1;

  always #5 CLK100MHZ = ~CLK100MHZ;

  moving_avg_filter_if #(.WIDTH(8)) bus_a ();
  moving_avg_filter_if #(.WIDTH(8)) bus_b ();

  moving_avg_filter #(.WIDTH(8), .LOG2_TAPS(2)) dut_a (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus_a)
  );

  moving_avg_filter #(.WIDTH(8), .LOG2_TAPS(3)) dut_b (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int q_a[$];
  int q_b[$];
  int res_a = 0;
  int res_b = 0;
  bit ov_a  = 1'b0;
  bit ov_b  = 1'b0;

  // Mean of the last N accepted samples, zeros standing in for missing ones.
  function automatic int window_avg(input int q[$], input int l);
    int s = 0;
    foreach (q[i]) s += q[i];
`ifdef MAVG_ROUND_EN
    return (s + (1 << (l - 1))) >>> l;
`else
    return s >>> l;
`endif
  endfunction

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    res_a = 0;
    res_b = 0;
    ov_a  = 1'b0;
    ov_b  = 1'b0;
  endtask

  task automatic step_a(input bit v, input bit c, input int s);
    bus_a.in_valid  = v;
    bus_a.clear     = c;
    bus_a.in_sample = 8'(s);
    @(posedge CLK100MHZ);
    #1;
    bus_a.in_valid = 1'b0;
    bus_a.clear    = 1'b0;
    if (c) begin
      q_a.delete();
      res_a = 0;
      ov_a  = 1'b0;
    end else if (v) begin
      q_a.push_back(s);
      if (q_a.size() > 4) void'(q_a.pop_front());
      res_a = window_avg(q_a, 2);
      ov_a  = (q_a.size() == 4);
    end else begin
      ov_a = 1'b0;
    end
  endtask

  task automatic step_b(input bit v, input bit c, input int s);
    bus_b.in_valid  = v;
    bus_b.clear     = c;
    bus_b.in_sample = 8'(s);
    @(posedge CLK100MHZ);
    #1;
    bus_b.in_valid = 1'b0;
    bus_b.clear    = 1'b0;
    if (c) begin
      q_b.delete();
      res_b = 0;
      ov_b  = 1'b0;
    end else if (v) begin
      q_b.push_back(s);
      if (q_b.size() > 8) void'(q_b.pop_front());
      res_b = window_avg(q_b, 3);
      ov_b  = (q_b.size() == 8);
    end else begin
      ov_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.primed !== 1'b0 || bus_a.result !== 8'sd0 ||
        bus_b.out_valid !== 1'b0 || bus_b.primed !== 1'b0 || bus_b.result !== 8'sd0) begin
      n_fail++;
      $display("FAIL reset: a ov=%0b pr=%0b res=%0d b ov=%0b pr=%0b res=%0d, expected all 0",
               bus_a.out_valid, bus_a.primed, bus_a.result,
               bus_b.out_valid, bus_b.primed, bus_b.result);
    end
  endtask

  task automatic test_warmup();
    int vals[4] = '{10, 20, 30, 40};
    foreach (vals[i]) begin
      step_a(1'b1, 1'b0, vals[i]);
      n_checks++;
      if (bus_a.out_valid !== ov_a || bus_a.primed !== (q_a.size() == 4) || bus_a.result !== 8'(res_a)) begin
        n_fail++;
        $display("FAIL warmup[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_a.out_valid, bus_a.primed, bus_a.result, ov_a, q_a.size() == 4, res_a);
      end
    end
    n_checks++;
    if (bus_a.result !== 8'sd25 || bus_a.out_valid !== 1'b1 || bus_a.primed !== 1'b1) begin
      n_fail++;
      $display("FAIL warmup_final: ov=%0b pr=%0b res=%0d, expected ov=1 pr=1 res=25",
               bus_a.out_valid, bus_a.primed, bus_a.result);
    end
  endtask

  task automatic test_slide();
    int vals[5] = '{50, 60, 70, 80, 90};
    foreach (vals[i]) begin
      step_a(1'b1, 1'b0, vals[i]);
      n_checks++;
      if (bus_a.out_valid !== ov_a || bus_a.primed !== (q_a.size() == 4) || bus_a.result !== 8'(res_a)) begin
        n_fail++;
        $display("FAIL slide[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_a.out_valid, bus_a.primed, bus_a.result, ov_a, q_a.size() == 4, res_a);
      end
    end
    n_checks++;
    if (bus_a.result !== 8'sd75) begin
      n_fail++;
      $display("FAIL slide_final: res=%0d, expected 75", bus_a.result);
    end
  endtask

  task automatic test_negative_rounding();
    int vals[4] = '{-1, -1, -1, -2};
    step_a(1'b0, 1'b1, 0);
    foreach (vals[i]) begin
      step_a(1'b1, 1'b0, vals[i]);
      n_checks++;
      if (bus_a.out_valid !== ov_a || bus_a.primed !== (q_a.size() == 4) || bus_a.result !== 8'(res_a)) begin
        n_fail++;
        $display("FAIL negative[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_a.out_valid, bus_a.primed, bus_a.result, ov_a, q_a.size() == 4, res_a);
      end
    end
    n_checks++;
`ifdef MAVG_ROUND_EN
    if (bus_a.result !== -8'sd1) begin
      n_fail++;
      $display("FAIL negative_final: res=%0d, expected -1", bus_a.result);
    end
`else
    if (bus_a.result !== -8'sd2) begin
      n_fail++;
      $display("FAIL negative_final: res=%0d, expected -2", bus_a.result);
    end
`endif
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 8; i++) begin
      step_a(1'b1, 1'b0, (i < 4) ? 127 : -128);
      n_checks++;
      if (bus_a.out_valid !== ov_a || bus_a.primed !== (q_a.size() == 4) || bus_a.result !== 8'(res_a)) begin
        n_fail++;
        $display("FAIL extremes[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_a.out_valid, bus_a.primed, bus_a.result, ov_a, q_a.size() == 4, res_a);
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if (bus_a.result !== ((i == 3) ? 8'sd127 : -8'sd128)) begin
          n_fail++;
          $display("FAIL extremes_window[%0d]: res=%0d, expected %0d",
                   i, bus_a.result, (i == 3) ? 127 : -128);
        end
      end
    end
  endtask

  task automatic test_gaps_and_clear();
    bit v_seq[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    step_a(1'b0, 1'b1, 0);
    foreach (v_seq[i]) begin
      step_a(v_seq[i], 1'b0, 4);
      n_checks++;
      if (bus_a.out_valid !== ov_a || bus_a.primed !== (q_a.size() == 4) || bus_a.result !== 8'(res_a)) begin
        n_fail++;
        $display("FAIL gaps[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_a.out_valid, bus_a.primed, bus_a.result, ov_a, q_a.size() == 4, res_a);
      end
    end
    step_a(1'b1, 1'b1, 99);
    n_checks++;
    if (bus_a.primed !== 1'b0 || bus_a.out_valid !== 1'b0 || bus_a.result !== 8'sd0) begin
      n_fail++;
      $display("FAIL clear_priority: ov=%0b pr=%0b res=%0d, expected ov=0 pr=0 res=0",
               bus_a.out_valid, bus_a.primed, bus_a.result);
    end
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, 1'b0, 4);
      n_checks++;
      if (bus_a.out_valid !== (i == 3) || bus_a.primed !== (i == 3) || bus_a.result !== 8'(res_a)) begin
        n_fail++;
        $display("FAIL after_clear[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_a.out_valid, bus_a.primed, bus_a.result, i == 3, i == 3, res_a);
      end
    end
    n_checks++;
    if (bus_a.result !== 8'sd4) begin
      n_fail++;
      $display("FAIL after_clear_final: res=%0d, expected 4", bus_a.result);
    end
  endtask

  task automatic test_async_reset();
    step_a(1'b0, 1'b1, 0);
    step_a(1'b1, 1'b0, 20);
    step_a(1'b1, 1'b0, 24);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.primed !== 1'b0 || bus_a.result !== 8'sd0) begin
      n_fail++;
      $display("FAIL async_reset: ov=%0b pr=%0b res=%0d, expected ov=0 pr=0 res=0",
               bus_a.out_valid, bus_a.primed, bus_a.result);
    end
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, 1'b0, 8);
      n_checks++;
      if (bus_a.out_valid !== ov_a || bus_a.primed !== (q_a.size() == 4) || bus_a.result !== 8'(res_a)) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_a.out_valid, bus_a.primed, bus_a.result, ov_a, q_a.size() == 4, res_a);
      end
    end
    n_checks++;
    if (bus_a.result !== 8'sd8 || bus_a.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_final: ov=%0b res=%0d, expected ov=1 res=8",
               bus_a.out_valid, bus_a.result);
    end
  endtask

  task automatic test_ramp_taps8();
    for (int i = 0; i < 16; i++) begin
      step_b(1'b1, 1'b0, i);
      n_checks++;
      if (bus_b.out_valid !== ov_b || bus_b.primed !== (q_b.size() == 8) || bus_b.result !== 8'(res_b)) begin
        n_fail++;
        $display("FAIL ramp8[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_b.out_valid, bus_b.primed, bus_b.result, ov_b, q_b.size() == 8, res_b);
      end
`ifndef MAVG_ROUND_EN
      if (i >= 7) begin
        n_checks++;
        if (bus_b.result !== 8'(i - 4)) begin
          n_fail++;
          $display("FAIL ramp8_value[%0d]: res=%0d, expected %0d", i, bus_b.result, i - 4);
        end
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit c;
      int s;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 39) == 0);
      s = int'($urandom_range(0, 255)) - 128;
      step_a(v, c, s);
      n_checks++;
      if (bus_a.out_valid !== ov_a || bus_a.primed !== (q_a.size() == 4) || bus_a.result !== 8'(res_a)) begin
        n_fail++;
        $display("FAIL random[%0d]: ov=%0b pr=%0b res=%0d, expected ov=%0b pr=%0b res=%0d",
                 i, bus_a.out_valid, bus_a.primed, bus_a.result, ov_a, q_a.size() == 4, res_a);
      end
    end
  endtask

  initial begin
    bus_a.clear     = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_sample = '0;
    bus_b.clear     = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_sample = '0;
    #23;
    reset = 1'b0;
    @(posedge CLK100MHZ);
    #1;
    test_reset();
    test_warmup();
    test_slide();
    test_negative_rounding();
    test_extremes();
    test_gaps_and_clear();
    test_async_reset();
    test_ramp_taps8();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
